// File: rtl/core_pkg.sv
// Core-wide widths and the request-source tag shared by the memory arbiter.
package core_pkg;
  localparam int Xlen     = 32;
  localparam int MaskBits = Xlen / 8;

  typedef enum logic {
    SrcInst = 1'b0,
    SrcData = 1'b1
  } src_e;
endpackage

// File: rtl/fifo_sync.sv
// Single-clock FIFO with full/empty flags; push and pop may occur in the same cycle.
module fifo_sync #(
  parameter int Width = 1,
  parameter int Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             i_push,
  input  logic [Width-1:0] i_data,
  input  logic             i_pop,
  output logic [Width-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int PtrW = $clog2(Depth);
  localparam logic [PtrW:0] CntFull = (PtrW+1)'(Depth);

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wptr;
  logic [PtrW-1:0]  r_rptr;
  logic [PtrW:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CntFull);
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rptr];

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end
endmodule

// File: rtl/mem_arbiter.sv
// Round-robin merge of the instruction and data request ports onto one memory port,
// with an in-order source-ID queue that steers each response back to its requester.
module mem_arbiter
  import core_pkg::*;
#(
  parameter int MaxOutstanding = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  output logic                imem_ready_o,
  input  logic                imem_valid_i,
  input  logic [Xlen-1:0]     imem_addr_i,
  input  logic [Xlen-1:0]     imem_wdata_i,
  input  logic [MaskBits-1:0] imem_wmask_i,
  output logic [Xlen-1:0]     imem_rdata_o,
  output logic                imem_rvalid_o,
  output logic                dmem_ready_o,
  input  logic                dmem_valid_i,
  input  logic [Xlen-1:0]     dmem_addr_i,
  input  logic [Xlen-1:0]     dmem_wdata_i,
  input  logic [MaskBits-1:0] dmem_wmask_i,
  output logic [Xlen-1:0]     dmem_rdata_o,
  output logic                dmem_rvalid_o,
  input  logic                mem_ready_i,
  output logic                mem_valid_o,
  output logic [Xlen-1:0]     mem_addr_o,
  output logic [Xlen-1:0]     mem_wdata_o,
  output logic [MaskBits-1:0] mem_wmask_o,
  input  logic [Xlen-1:0]     mem_rdata_i,
  input  logic                mem_rvalid_i
);
  src_e r_prio;
  src_e r_lock_src;
  logic r_lock;

  src_e w_grant;
  src_e w_head;
  logic w_head_bit;
  logic w_gnt_valid;
  logic w_full;
  logic w_empty;
  logic w_accept;
  logic w_stall;
  logic w_pop;

  always_comb begin
    w_grant = SrcInst;
    if (r_lock)                            w_grant = r_lock_src;
    else if (imem_valid_i && dmem_valid_i) w_grant = r_prio;
    else if (dmem_valid_i)                 w_grant = SrcData;
  end

  assign w_gnt_valid = (w_grant == SrcData) ? dmem_valid_i : imem_valid_i;
  assign mem_valid_o = rst_ni && w_gnt_valid && !w_full;
  assign mem_addr_o  = (w_grant == SrcData) ? dmem_addr_i  : imem_addr_i;
  assign mem_wdata_o = (w_grant == SrcData) ? dmem_wdata_i : imem_wdata_i;
  assign mem_wmask_o = (w_grant == SrcData) ? dmem_wmask_i : imem_wmask_i;

  assign imem_ready_o = rst_ni && (w_grant == SrcInst) && mem_ready_i && !w_full;
  assign dmem_ready_o = rst_ni && (w_grant == SrcData) && mem_ready_i && !w_full;

  assign w_accept = mem_valid_o && mem_ready_i;
  assign w_stall  = mem_valid_o && !mem_ready_i;

  // A presented-but-stalled request pins the grant so the shared port stays stable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_prio     <= SrcInst;
      r_lock     <= 1'b0;
      r_lock_src <= SrcInst;
    end else begin
      r_lock <= w_stall;
      if (w_stall)  r_lock_src <= w_grant;
      if (w_accept) r_prio <= (w_grant == SrcInst) ? SrcData : SrcInst;
    end
  end

  fifo_sync #(
    .Width(1),
    .Depth(MaxOutstanding)
  ) u_id_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .i_push (w_accept),
    .i_data (w_grant),
    .i_pop  (w_pop),
    .o_data (w_head_bit),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  assign w_head = src_e'(w_head_bit);
  assign w_pop  = rst_ni && mem_rvalid_i && !w_empty;

  assign imem_rvalid_o = w_pop && (w_head == SrcInst);
  assign dmem_rvalid_o = w_pop && (w_head == SrcData);
  assign imem_rdata_o  = mem_rdata_i;
  assign dmem_rdata_o  = mem_rdata_i;

  // A response with nothing outstanding is dropped.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(mem_rvalid_i && w_empty))
        else $warning("mem_arbiter: mem_rvalid_i with no outstanding request, response dropped");
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand-written lock/reset sequences,
// and a randomized run checked against a queue-based model of the arbitration rules.
module tb_mem_arbiter;
  import core_pkg::*;

  logic                clk_i = 1'b0;
  logic                rst_ni = 1'b0;
  logic                imem_ready_o, imem_valid_i, imem_rvalid_o;
  logic [Xlen-1:0]     imem_addr_i, imem_wdata_i, imem_rdata_o;
  logic [MaskBits-1:0] imem_wmask_i;
  logic                dmem_ready_o, dmem_valid_i, dmem_rvalid_o;
  logic [Xlen-1:0]     dmem_addr_i, dmem_wdata_i, dmem_rdata_o;
  logic [MaskBits-1:0] dmem_wmask_i;
  logic                mem_ready_i, mem_valid_o, mem_rvalid_i;
  logic [Xlen-1:0]     mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [MaskBits-1:0] mem_wmask_o;

  always #5 clk_i = ~clk_i;

  mem_arbiter #(.MaxOutstanding(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .imem_ready_o(imem_ready_o), .imem_valid_i(imem_valid_i), .imem_addr_i(imem_addr_i),
    .imem_wdata_i(imem_wdata_i), .imem_wmask_i(imem_wmask_i), .imem_rdata_o(imem_rdata_o),
    .imem_rvalid_o(imem_rvalid_o),
    .dmem_ready_o(dmem_ready_o), .dmem_valid_i(dmem_valid_i), .dmem_addr_i(dmem_addr_i),
    .dmem_wdata_i(dmem_wdata_i), .dmem_wmask_i(dmem_wmask_i), .dmem_rdata_o(dmem_rdata_o),
    .dmem_rvalid_o(dmem_rvalid_o),
    .mem_ready_i(mem_ready_i), .mem_valid_o(mem_valid_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o), .mem_rdata_i(mem_rdata_i),
    .mem_rvalid_i(mem_rvalid_i)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        iv, dv, mr, rv;
    logic [31:0] rd;
    logic        e_mv;
    src_e        e_src;
    logic        e_irdy, e_drdy, e_irv, e_drv;
  } vec_t;

  vec_t tbl[$];

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic add_row(input int iv, input int dv, input int mr, input int rv,
                         input logic [31:0] rd, input int mv, input src_e s,
                         input int ir, input int dr, input int irv, input int drv);
    vec_t r;
    r.iv = (iv != 0); r.dv = (dv != 0); r.mr = (mr != 0); r.rv = (rv != 0);
    r.rd = rd; r.e_mv = (mv != 0); r.e_src = s;
    r.e_irdy = (ir != 0); r.e_drdy = (dr != 0); r.e_irv = (irv != 0); r.e_drv = (drv != 0);
    tbl.push_back(r);
  endtask

  // Drive one cycle's inputs just after the falling edge, then let logic settle.
  task automatic drive(input logic iv, input logic dv, input logic mr,
                       input logic rv, input logic [31:0] rd);
    @(negedge clk_i);
    imem_valid_i = iv; dmem_valid_i = dv; mem_ready_i = mr;
    mem_rvalid_i = rv; mem_rdata_i = rd;
    #1;
  endtask

  task automatic check_out(input string tag, input logic e_mv, input src_e e_src,
                           input logic chk_rdy, input logic e_irdy, input logic e_drdy,
                           input logic e_irv, input logic e_drv, input logic [31:0] e_rd);
    chk1({tag, ".mem_valid"}, mem_valid_o, e_mv);
    if (e_mv) begin
      chk32({tag, ".addr"},  mem_addr_o,  (e_src == SrcData) ? dmem_addr_i  : imem_addr_i);
      chk32({tag, ".wdata"}, mem_wdata_o, (e_src == SrcData) ? dmem_wdata_i : imem_wdata_i);
      chk32({tag, ".wmask"}, {28'b0, mem_wmask_o},
            {28'b0, (e_src == SrcData) ? dmem_wmask_i : imem_wmask_i});
    end
    if (chk_rdy) begin
      chk1({tag, ".imem_ready"}, imem_ready_o, e_irdy);
      chk1({tag, ".dmem_ready"}, dmem_ready_o, e_drdy);
    end
    chk1({tag, ".imem_rvalid"}, imem_rvalid_o, e_irv);
    chk1({tag, ".dmem_rvalid"}, dmem_rvalid_o, e_drv);
    if (e_irv) chk32({tag, ".imem_rdata"}, imem_rdata_o, e_rd);
    if (e_drv) chk32({tag, ".dmem_rdata"}, dmem_rdata_o, e_rd);
  endtask

  // Reference model state for the randomized run.
  src_e q[$];
  src_e last_w, lock_s, g;
  logic locked, ip, dp, full, gv, e_mv, mr, rv, acc;
  logic [31:0] rd;

  initial begin
    imem_valid_i = 0; dmem_valid_i = 0; mem_ready_i = 0; mem_rvalid_i = 0;
    imem_addr_i = '0; imem_wdata_i = '0; imem_wmask_i = '0;
    dmem_addr_i = '0; dmem_wdata_i = '0; dmem_wmask_i = '0; mem_rdata_i = '0;

    // Reset values.
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    check_out("reset", 0, SrcInst, 1, 0, 0, 0, 0, 0);

    // Single instruction read at 0x0, response two cycles later.
    @(negedge clk_i); rst_ni = 1'b1;
    drive(1, 0, 1, 0, 0);
    check_out("ird.acc", 1, SrcInst, 1, 1, 0, 0, 0, 0);
    chk32("ird.addr0", mem_addr_o, 32'h0);
    drive(0, 0, 0, 0, 0);
    check_out("ird.wait", 0, SrcInst, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 32'h0000_0013);
    check_out("ird.rsp", 0, SrcInst, 1, 0, 0, 1, 0, 32'h0000_0013);

    // Vector table: alternation, FIFO full, reopen, push+pop at occupancy 2.
    imem_addr_i = 32'h1000; imem_wdata_i = 32'h0;    imem_wmask_i = 4'h0;
    dmem_addr_i = 32'h2000; dmem_wdata_i = 32'hD0D0; dmem_wmask_i = 4'h3;
    add_row(1,1,1,0,32'h00, 1,SrcData, 0,1,0,0);
    add_row(1,1,1,1,32'h11, 1,SrcInst, 1,0,0,1);
    add_row(1,1,1,1,32'h22, 1,SrcData, 0,1,1,0);
    add_row(1,1,1,1,32'h33, 1,SrcInst, 1,0,0,1);
    add_row(0,0,0,1,32'h44, 0,SrcInst, 0,0,1,0);
    add_row(1,0,1,0,32'h00, 1,SrcInst, 1,0,0,0);
    add_row(1,0,1,0,32'h00, 1,SrcInst, 1,0,0,0);
    add_row(1,0,1,0,32'h00, 1,SrcInst, 1,0,0,0);
    add_row(1,0,1,0,32'h00, 1,SrcInst, 1,0,0,0);
    add_row(1,1,1,1,32'h55, 0,SrcInst, 0,0,1,0);
    add_row(1,1,1,0,32'h00, 1,SrcData, 0,1,0,0);
    add_row(0,0,0,1,32'h66, 0,SrcInst, 0,0,1,0);
    add_row(0,0,0,1,32'h77, 0,SrcInst, 0,0,1,0);
    add_row(1,0,1,1,32'h88, 1,SrcInst, 1,0,1,0);
    add_row(0,0,0,1,32'h99, 0,SrcInst, 0,0,0,1);
    add_row(0,0,0,1,32'hAA, 0,SrcInst, 0,0,1,0);
    foreach (tbl[i]) begin
      drive(tbl[i].iv, tbl[i].dv, tbl[i].mr, tbl[i].rv, tbl[i].rd);
      check_out($sformatf("vec%0d", i), tbl[i].e_mv, tbl[i].e_src, 1,
                tbl[i].e_irdy, tbl[i].e_drdy, tbl[i].e_irv, tbl[i].e_drv, tbl[i].rd);
    end

    // Make data the last winner so an unlocked arbiter would pick instruction next.
    dmem_addr_i = 32'h300;
    drive(0, 1, 1, 0, 0);
    check_out("pre.acc", 1, SrcData, 1, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 32'h1);
    check_out("pre.rsp", 0, SrcInst, 1, 0, 0, 0, 1, 32'h1);

    // Stalled data write must hold the shared port while instruction raises valid.
    dmem_addr_i = 32'h100; dmem_wdata_i = 32'hDEADBEEF; dmem_wmask_i = 4'hF;
    drive(0, 1, 0, 0, 0);
    check_out("lock0", 1, SrcData, 1, 0, 0, 0, 0, 0);
    for (int k = 1; k < 3; k++) begin
      drive(1, 1, 0, 0, 0);
      check_out($sformatf("lock%0d", k), 1, SrcData, 1, 0, 0, 0, 0, 0);
      chk32($sformatf("lock%0d.wdata", k), mem_wdata_o, 32'hDEADBEEF);
    end
    drive(1, 1, 1, 0, 0);
    check_out("lock.acc", 1, SrcData, 1, 0, 1, 0, 0, 0);
    chk32("lock.addr", mem_addr_o, 32'h100);
    drive(1, 0, 1, 0, 0);
    check_out("lock.inst", 1, SrcInst, 1, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 32'h2);
    check_out("lock.rsp0", 0, SrcInst, 1, 0, 0, 0, 1, 32'h2);
    drive(0, 0, 0, 1, 32'h3);
    check_out("lock.rsp1", 0, SrcInst, 1, 0, 0, 1, 0, 32'h3);

    // Reset with three data requests outstanding.
    for (int k = 0; k < 3; k++) drive(0, 1, 1, 0, 0);
    @(negedge clk_i);
    rst_ni = 1'b0; imem_valid_i = 1; dmem_valid_i = 1; mem_ready_i = 1; mem_rvalid_i = 1;
    #1;
    check_out("rst.mid", 0, SrcInst, 1, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    rst_ni = 1'b1; imem_valid_i = 0; dmem_valid_i = 0; mem_ready_i = 0; mem_rvalid_i = 0;
    drive(0, 0, 0, 1, 32'h4);
    check_out("rst.spurious", 0, SrcInst, 1, 0, 0, 0, 0, 0);
    drive(1, 1, 1, 0, 0);
    check_out("rst.prio", 1, SrcInst, 1, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 32'h5);
    check_out("rst.rsp", 0, SrcInst, 1, 0, 0, 1, 0, 32'h5);

    // Randomized run against the queue model; last accepted transfer was instruction.
    last_w = SrcInst; locked = 0; lock_s = SrcInst; ip = 0; dp = 0;
    for (int c = 0; c < 2000; c++) begin
      if (!ip && $urandom_range(1) == 1) begin
        imem_addr_i = $urandom; imem_wdata_i = $urandom; imem_wmask_i = 4'($urandom);
        ip = 1;
      end
      if (!dp && $urandom_range(1) == 1) begin
        dmem_addr_i = $urandom; dmem_wdata_i = $urandom; dmem_wmask_i = 4'($urandom);
        dp = 1;
      end
      mr = ($urandom_range(3) != 0);
      rv = (q.size() > 0) && ($urandom_range(2) != 0);
      rd = $urandom;
      drive(ip, dp, mr, rv, rd);

      if (locked)        g = lock_s;
      else if (ip && dp) g = (last_w == SrcInst) ? SrcData : SrcInst;
      else if (dp)       g = SrcData;
      else               g = SrcInst;
      gv   = (g == SrcData) ? dp : ip;
      full = (q.size() >= 4);
      e_mv = gv && !full;
      check_out($sformatf("rnd%0d", c), e_mv, g, ip || dp,
                (g == SrcInst) && mr && !full, (g == SrcData) && mr && !full,
                rv && (q[0] == SrcInst), rv && (q[0] == SrcData), rd);

      acc = e_mv && mr;
      if (rv) void'(q.pop_front());
      if (acc) begin
        q.push_back(g);
        last_w = g;
        if (g == SrcData) dp = 0; else ip = 0;
      end
      locked = e_mv && !mr;
      if (locked) lock_s = g;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
